// File: rtl/log_output_error_unit.sv
// Serial log-domain FIR output and error stage: sums TAPS Mitchell-antilog products into y(n),
// forms e(n) = d(n) - y(n), and converts mu*e(n) to log format. Latency TAPS+4 cycles; start ignored while busy.
module log_output_error_unit #(
    parameter int WIDTH     = 16,
    parameter int QP        = 12,
    parameter int LOG_WIDTH = 17,
    parameter int TAPS      = 8,
    parameter int ACC_WIDTH = 24,
    parameter int LOG_MU    = -5
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [WIDTH-1:0]                           d_in,
    output logic                                       tap_req,
    output logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] tap_idx,
    input  logic [LOG_WIDTH-1:0]                       log_weight,
    input  logic [LOG_WIDTH-1:0]                       log_x,
    input  logic                                       log_weight_sign,
    input  logic                                       log_x_sign,
    input  logic                                       log_weight_valid,
    input  logic                                       log_x_valid,
    output logic [WIDTH-1:0]                           y_out,
    output logic [WIDTH-1:0]                           error_out,
    output logic [LOG_WIDTH-1:0]                       log_mu_error,
    output logic                                       log_error_sign,
    output logic                                       log_error_valid,
    output logic                                       busy,
    output logic                                       done
);
    localparam int IDXW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int LI   = LOG_WIDTH - 12;
    localparam int SH_L = (QP >= 12) ? QP - 12 : 0;
    localparam int SH_R = (QP < 12) ? 12 - QP : 0;
    localparam int LI_MAX = (1 << (LI - 1)) - 1;
    localparam int LI_MIN = -(1 << (LI - 1));

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_ERR   = 3'd3;
    localparam logic [2:0] S_LOG   = 3'd4;

    localparam logic [63:0]                 MAG_MAX = (64'd1 << (WIDTH - 1)) - 64'd1;
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX   = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN   = ~Y_MAX;
    localparam logic [WIDTH-1:0]            W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]            W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]                  state;
    logic                        drain_cnt;
    logic [WIDTH-1:0]            d_reg;
    logic                        req_d1;
    logic                        pvld_r;
    logic [LOG_WIDTH-1:0]        plog_r;
    logic                        psign_r;
    logic                        pval_r;
    logic signed [ACC_WIDTH-1:0] acc;

    // Product in log domain: add exponents, clamp to the representable Q5.12 range
    logic signed [LOG_WIDTH:0]   psum;
    logic [LOG_WIDTH-1:0]        psat;
    always_comb begin
        psum = {log_weight[LOG_WIDTH-1], log_weight} + {log_x[LOG_WIDTH-1], log_x};
        psat = psum[LOG_WIDTH-1:0];
        if (psum[LOG_WIDTH] != psum[LOG_WIDTH-1])
            psat = psum[LOG_WIDTH] ? {1'b1, {(LOG_WIDTH-1){1'b0}}} : {1'b0, {(LOG_WIDTH-1){1'b1}}};
    end

    // Mitchell antilog of the registered product
    int                          ex_i;
    logic [63:0]                 shifted;
    logic [WIDTH-1:0]            mag;
    logic signed [ACC_WIDTH-1:0] term;
    always_comb begin
        ex_i = int'($signed(plog_r[LOG_WIDTH-1:12]));
        if (ex_i >= 0)
            shifted = 64'({1'b1, plog_r[11:0]}) << ex_i;
        else
            shifted = 64'({1'b1, plog_r[11:0]}) >> (-ex_i);
        shifted = (shifted << SH_L) >> SH_R;
        mag  = (shifted > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : shifted[WIDTH-1:0];
        term = '0;
        if (pval_r)
            term = psign_r ? -$signed(ACC_WIDTH'(mag)) : $signed(ACC_WIDTH'(mag));
    end

    logic [WIDTH-1:0] y_sat;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] e_sat;
    always_comb begin
        if (acc > Y_MAX)      y_sat = W_MAX;
        else if (acc < Y_MIN) y_sat = W_MIN;
        else                  y_sat = acc[WIDTH-1:0];
        diff  = {d_reg[WIDTH-1], d_reg} - {y_sat[WIDTH-1], y_sat};
        e_sat = diff[WIDTH-1:0];
        if (diff[WIDTH] != diff[WIDTH-1])
            e_sat = diff[WIDTH] ? W_MIN : W_MAX;
    end

    // Log conversion of |e|; the integer part clamps rather than wrapping for tiny errors
    logic [WIDTH-1:0]     abs_e;
    int                   lead;
    int                   int_part;
    logic [11:0]          frac;
    logic [LOG_WIDTH-1:0] log_val;
    always_comb begin
        if (error_out == W_MIN)        abs_e = W_MAX;
        else if (error_out[WIDTH-1])   abs_e = -error_out;
        else                           abs_e = error_out;
        lead = 0;
        for (int i = 0; i < WIDTH; i++)
            if (abs_e[i]) lead = i;
        frac = 12'((abs_e << (WIDTH - 1 - lead)) >> (WIDTH - 13));
        int_part = lead - QP + LOG_MU;
        if (int_part > LI_MAX) int_part = LI_MAX;
        if (int_part < LI_MIN) int_part = LI_MIN;
        log_val = {LI'(int_part), frac};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            drain_cnt       <= 1'b0;
            d_reg           <= '0;
            req_d1          <= 1'b0;
            pvld_r          <= 1'b0;
            plog_r          <= '0;
            psign_r         <= 1'b0;
            pval_r          <= 1'b0;
            acc             <= '0;
            tap_req         <= 1'b0;
            tap_idx         <= '0;
            y_out           <= '0;
            error_out       <= '0;
            log_mu_error    <= '0;
            log_error_sign  <= 1'b0;
            log_error_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done    <= 1'b0;
            req_d1  <= tap_req;
            pvld_r  <= req_d1;
            plog_r  <= psat;
            psign_r <= log_weight_sign ^ log_x_sign;
            pval_r  <= log_weight_valid & log_x_valid;
            if (pvld_r)
                acc <= acc + term;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d_reg   <= d_in;
                        acc     <= '0;
                        tap_idx <= '0;
                        tap_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (tap_idx == IDXW'(TAPS - 1)) begin
                        tap_req   <= 1'b0;
                        tap_idx   <= '0;
                        drain_cnt <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt)
                        state <= S_ERR;
                end
                S_ERR: begin
                    y_out     <= y_sat;
                    error_out <= e_sat;
                    state     <= S_LOG;
                end
                S_LOG: begin
                    log_error_valid <= (abs_e != '0);
                    log_mu_error    <= (abs_e != '0) ? log_val : '0;
                    log_error_sign  <= error_out[WIDTH-1];
                    done            <= 1'b1;
                    busy            <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/log_output_error_unit.md
# log_output_error_unit

Time-multiplexed filter-output and error stage of the log-domain FLAF datapath. Once per input sample it reads the TAPS log-domain weights and expanded inputs serially, forms each product by log addition, converts it back to linear with a Mitchell antilog, and accumulates the results into y(n). It then computes e(n) = d(n) − y(n) and converts μ·e(n) to the log format. That log value drives the log_mu_error / log_error_sign / log_error_valid inputs of every weight-update tap.

## Interface
- WIDTH, 16, linear word width, signed, Q(WIDTH−QP).QP
- QP, 12, linear fractional bits
- LOG_WIDTH, 17, log word: signed 5-bit integer part, 12-bit fraction (Q5.12)
- TAPS, 8, number of weight taps read per sample
- ACC_WIDTH, 24, signed accumulator width
- LOG_MU, −5, step size μ = 2^LOG_MU, added to the log integer part

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  sample strobe; sampled only in IDLE
- d_in  in  WIDTH  desired sample; latched on the accepted start
- tap_req  out  1  tap-read request
- tap_idx  out  clog2(TAPS)  tap index to read
- log_weight, log_x  in  LOG_WIDTH  tap data for the previous cycle's tap_idx
- log_weight_sign, log_x_sign  in  1  sign (1 = negative)
- log_weight_valid, log_x_valid  in  1  0 = value is exactly zero
- y_out  out  WIDTH  filter output
- error_out  out  WIDTH  e(n)
- log_mu_error  out  LOG_WIDTH  log2|μ·e|
- log_error_sign  out  1  sign of e
- log_error_valid  out  1  0 when e = 0
- busy  out  1  sample in progress
- done  out  1  one-cycle pulse; all result outputs are valid

## Operation
- **States:** IDLE → FETCH (TAPS cycles) → DRAIN (2 cycles) → ERR (1 cycle) → LOG (1 cycle) → IDLE.
- **Start:** start accepted in IDLE only, and ignored in every other state. On acceptance, latch d_in, clear the accumulator, set tap_idx = 0 and tap_req = 1.
- **FETCH:** tap_idx counts 0..TAPS−1, one step per cycle. tap_req drops when FETCH ends.
- **Tap data contract:** the source registers tap_idx and returns that tap's data on the following cycle.
- **Product (registered stage):**
  - plog = log_weight + log_x, saturated to the signed LOG_WIDTH range.
  - psign = XOR of the two signs.
  - pvalid = AND of the two valids.
- **Antilog:**
  - Exponent e = integer part of plog; mantissa m = {1, frac} (13 bits).
  - Magnitude = m << e for e ≥ 0, or m >> −e (truncating) for e < 0, then scaled by 2^(QP−12).
  - Magnitude saturates to 2^(WIDTH−1)−1. Negate if psign. Term = 0 if !pvalid.
- **Accumulate (registered stage):** acc += term, ACC_WIDTH wide, no wrap for legal TAPS.
- **ERR:**
  - y = acc saturated to WIDTH.
  - e = d − y, computed at WIDTH+1 bits and saturated to WIDTH.
  - Both registered to y_out and error_out.
- **LOG:**
  - |e| with −2^(WIDTH−1) mapped to 2^(WIDTH−1)−1.
  - If |e| = 0: log_error_valid = 0 and log_mu_error = 0.
  - Otherwise, with p = index of the leading one:
    - integer part = p − QP + LOG_MU;
    - fraction = the bits below the leading one, left-aligned into 12 bits (zero-padded, excess truncated).
  - log_error_sign = e[WIDTH−1].
- **Output hold:** result outputs hold their values until the next LOG cycle.

## Timing
- Let edge 0 be the edge that samples start.
- Tap i request: tap_idx = i after edge i. Data sampled into the product register at edge i+2; accumulated at edge i+3.
- Final accumulation at edge TAPS+2. y_out and error_out update at edge TAPS+3.
- log outputs update and done rises at edge TAPS+4; for TAPS = 8 that is edge 12.
- busy is high from edge 0 and falls at edge TAPS+4, so a start during the done cycle is accepted (back-to-back samples).
- **Reset values:**
  - state IDLE;
  - tap_req, tap_idx, busy, done = 0;
  - y_out, error_out, log_mu_error, log_error_sign, log_error_valid, accumulator = 0.
- **Reset mid-sample:** the sample is aborted and no done is produced.

## Test plan
- **Zero weights:** all taps have log_weight_valid = 0, d_in = 0x1000 → y_out = 0, error_out = 4096, log_mu_error = 0x1B000, sign 0, valid 1; done at edge 12.
- **Single tap:** tap 0 has weight 0x00000 and x 0x1F000 (0.5), both valid; other taps invalid; d_in = 0 → y_out = 2048, error_out = −2048, log_mu_error = 0x1A000, sign 1.
- **Saturation:** all 8 taps have weight = x = 0x02000, d_in = 0x8000:
  - each term saturates to 32767, y_out = 32767;
  - error_out = −32768, log_mu_error = 0x1DFFF, sign 1.
- **Zero error:** d_in equals the computed y → log_error_valid = 0, log_mu_error = 0.
- **Handshake:**
  - start pulsed at edges 3 and 7 during busy → ignored;
  - tap_idx sequence is 0..7 with tap_req high for exactly 8 cycles;
  - start in the done cycle → new sample begins immediately.
- **Reset abort:** reset asserted at edge 5 → all outputs read 0 the next cycle, no done, and a fresh start then completes normally.
